// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (data/instruction cache) single-outstanding arbiter in front of a four-banked memory.
// Define ARB_RR_EN for round-robin arbitration; otherwise the data cache has fixed priority.
module mem_arbiter #(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        d_ack,
  output logic        i_ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic [3:0]  mem_busy,
  input  logic        mem_stall,
  input  logic        mem_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, DONE} state_t;
  state_t state, next;
  logic [2:0] cnt;
  logic gnt_i, wr, err_flag, pick_i, go;
  logic [15:0] addr, wdata;
`ifdef ARB_RR_EN
  logic last_d;
  assign pick_i = i_req && (!d_req || last_d);
`else
  assign pick_i = i_req && !d_req;
`endif
  assign go = !mem_busy[addr[2:1]] && !mem_stall;
  always_comb begin
    next = state;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    d_ack = 1'b0;
    i_ack = 1'b0;
    err = 1'b0;
    mem_addr = (state == IDLE) ? '0 : addr;
    mem_wdata = (state == IDLE) ? '0 : wdata;
    case (state)
      IDLE: next = (d_req || i_req) ? ISSUE : IDLE;
      ISSUE: begin
        mem_rd = go && !wr;
        mem_wr = go && wr;
        next = !go ? ISSUE : wr ? DONE : RD_WAIT;
      end
      RD_WAIT: next = (cnt == 3'(RD_LAT)) ? DONE : RD_WAIT;
      default: begin
        d_ack = !gnt_i;
        i_ack = gnt_i;
        err = err_flag;
        next = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      gnt_i <= 1'b0;
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      err_flag <= 1'b0;
      rdata <= '0;
`ifdef ARB_RR_EN
      last_d <= 1'b1;
`endif
    end else begin
      state <= next;
      if (state == IDLE && (d_req || i_req)) begin
        gnt_i <= pick_i;
        addr <= pick_i ? i_addr : d_addr;
        wdata <= pick_i ? '0 : d_wdata;
        wr <= !pick_i && d_wr;
`ifdef ARB_RR_EN
        last_d <= !pick_i;
`endif
      end
      // cnt reaches 1 with the issue cycle; data arrives RD_LAT cycles after the strobe
      cnt <= (state == ISSUE) ? 3'd1 : (state == RD_WAIT) ? cnt + 3'd1 : cnt;
      if (state == RD_WAIT && cnt == 3'(RD_LAT))
        rdata <= mem_rdata;
      err_flag <= (state == DONE || state == IDLE) ? 1'b0 : (err_flag || mem_err);
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transaction-level checks of mem_arbiter against a timing model.
module tb_mem_arbiter;
  localparam int RD_LAT = 2;
  logic clk = 1'b0, rst;
  logic d_req, d_wr, i_req, d_ack, i_ack, err, mem_wr, mem_rd, mem_stall, mem_err;
  logic [15:0] d_addr, d_wdata, i_addr, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_busy;
  int errors = 0, checks = 0;
  logic [15:0] m_rdata;
  bit m_last_d;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_req(i_req), .i_addr(i_addr), .d_ack(d_ack), .i_ack(i_ack), .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_stall(mem_stall), .mem_err(mem_err)
  );

  // One access from an IDLE cycle (called at posedge+1) through the cycle after its ack.
  task automatic do_access(input bit dq, input bit dwr, input logic [15:0] da, input logic [15:0] dwd,
                           input bit iq, input logic [15:0] ia, input bit rnd,
                           input logic [3:0] bpat, input int bn, input int err_rel, input logic [15:0] rv);
    bit win_i, ewr, issued, eerr, done, exp_rd, exp_wr;
    logic [15:0] ea, ew, erd;
    int ic, ack_t;
`ifdef ARB_RR_EN
    win_i = iq && (!dq || m_last_d);
`else
    win_i = iq && !dq;
`endif
    ea = win_i ? ia : da;
    ew = win_i ? 16'h0 : dwd;
    ewr = !win_i && dwr;
    issued = 0; eerr = 0; done = 0; ic = 0; ack_t = -1; erd = m_rdata;
    d_req = dq; d_wr = dwr; d_addr = da; d_wdata = dwd; i_req = iq; i_addr = ia;
    mem_busy = 4'h0; mem_stall = 1'b0; mem_err = 1'b0; mem_rdata = rv;
    @(negedge clk);
    checks++;
    if (mem_addr !== 16'h0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || d_ack !== 1'b0 || i_ack !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle: addr=%h rd=%b wr=%b d_ack=%b i_ack=%b err=%b, required all 0",
               mem_addr, mem_rd, mem_wr, d_ack, i_ack, err);
    end
    for (int t = 1; t <= 300 && !done; t++) begin
      @(posedge clk); #1;
      if (rnd) begin
        mem_busy = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        mem_stall = ($urandom_range(0, 3) == 0);
        mem_rdata = 16'($urandom);
        mem_err = ($urandom_range(0, 9) == 0);
        if (win_i) begin
          i_addr = 16'($urandom);
          if ($urandom_range(0, 1) == 1) i_req = 1'b0;
        end else begin
          d_addr = 16'($urandom);
          d_wdata = 16'($urandom);
          d_wr = 1'($urandom);
          if ($urandom_range(0, 1) == 1) d_req = 1'b0;
        end
      end else begin
        mem_busy = (t <= bn) ? bpat : 4'h0;
        mem_stall = 1'b0;
        mem_rdata = rv;
        mem_err = issued && (t == ic + err_rel);
      end
      if (t == ack_t) mem_err = 1'b0;
      exp_rd = 0; exp_wr = 0;
      if (!issued && !mem_busy[ea[2:1]] && !mem_stall) begin
        issued = 1; ic = t;
        ack_t = ewr ? t + 1 : t + RD_LAT + 1;
        exp_rd = !ewr; exp_wr = ewr;
      end
      if (issued && !ewr && t == ic + RD_LAT) erd = mem_rdata;
      if (mem_err) eerr = 1;
      @(negedge clk);
      checks++;
      if (mem_addr !== ea || mem_wdata !== ew) begin
        errors++;
        $display("FAIL fields t=%0d: addr=%h wdata=%h, required addr=%h wdata=%h", t, mem_addr, mem_wdata, ea, ew);
      end
      checks++;
      if (mem_rd !== exp_rd || mem_wr !== exp_wr) begin
        errors++;
        $display("FAIL strobe t=%0d: rd=%b wr=%b, required rd=%b wr=%b", t, mem_rd, mem_wr, exp_rd, exp_wr);
      end
      checks++;
      if (d_ack !== (t == ack_t && !win_i) || i_ack !== (t == ack_t && win_i) || err !== (t == ack_t && eerr)) begin
        errors++;
        $display("FAIL ack t=%0d: d_ack=%b i_ack=%b err=%b, required d_ack=%b i_ack=%b err=%b (ack cycle %0d)",
                 t, d_ack, i_ack, err, t == ack_t && !win_i, t == ack_t && win_i, t == ack_t && eerr, ack_t);
      end
      if (t == ack_t) begin
        checks++;
        if (rdata !== erd) begin
          errors++;
          $display("FAIL rdata: got %h, required %h", rdata, erd);
        end
        m_rdata = erd;
        m_last_d = !win_i;
        done = 1;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout: no ack within 300 cycles");
    end
    @(posedge clk); #1;
    if (win_i) i_req = 1'b0; else d_req = 1'b0;
    mem_busy = 4'h0; mem_stall = 1'b0; mem_err = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0; i_req = 0; i_addr = 0;
    mem_rdata = 0; mem_busy = 0; mem_stall = 0; mem_err = 0;
    m_rdata = 16'h0; m_last_d = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({d_ack, i_ack, err, mem_wr, mem_rd} !== 5'b0 || rdata !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: acks/err/strobes=%b rdata=%h addr=%h wdata=%h, required 0",
               {d_ack, i_ack, err, mem_wr, mem_rd}, rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_write;
    do_access(1, 1, 16'h0010, 16'hBEEF, 0, 16'h0, 0, 4'h0, 0, -1, 16'h0);
  endtask

  task automatic test_read;
    do_access(0, 0, 16'h0, 16'h0, 1, 16'h0004, 0, 4'h0, 0, -1, 16'h1234);
  endtask

  task automatic test_busy;
    do_access(0, 0, 16'h0, 16'h0, 1, 16'h0002, 0, 4'b0010, 3, -1, 16'hA5C3);
  endtask

  task automatic test_arbitration;
    do_access(1, 0, 16'h0100, 16'h0, 1, 16'h0200, 0, 4'h0, 0, -1, 16'h1111);
    do_access(d_req, 0, 16'h0100, 16'h0, i_req, 16'h0200, 0, 4'h0, 0, -1, 16'h2222);
    for (int k = 0; k < 4; k++)
      do_access(1, 0, 16'h0300, 16'h0, 1, 16'h0408, 0, 4'h0, 0, -1, 16'(16'h3000 + k));
    d_req = 1'b0; i_req = 1'b0;
  endtask

  task automatic test_err;
    do_access(0, 0, 16'h0, 16'h0, 1, 16'h0008, 0, 4'h0, 0, 1, 16'h5555);
    do_access(1, 0, 16'h0020, 16'h0, 0, 16'h0, 0, 4'h0, 0, -1, 16'h6666);
  endtask

  task automatic test_reset_mid;
    i_req = 1'b1; i_addr = 16'h0006; mem_rdata = 16'h7777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({d_ack, i_ack, err, mem_wr, mem_rd} !== 5'b0 || rdata !== 16'h0 || mem_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: acks/err/strobes=%b rdata=%h addr=%h, required 0",
               {d_ack, i_ack, err, mem_wr, mem_rd}, rdata, mem_addr);
    end
    m_rdata = 16'h0; m_last_d = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_access(0, 0, 16'h0, 16'h0, 1, 16'h0006, 0, 4'h0, 0, -1, 16'h7777);
  endtask

  task automatic test_random;
    bit dp = 0, ip = 0, dw = 0;
    logic [15:0] da = 0, dd = 0, ia = 0;
    for (int n = 0; n < 60; n++) begin
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; dw = 1'($urandom); da = 16'($urandom); dd = 16'($urandom);
      end
      if (!ip && (!dp || $urandom_range(0, 1) == 1)) begin
        ip = 1; ia = 16'($urandom);
      end
      do_access(dp, dw, da, dd, ip, ia, 1, 4'h0, 0, -1, 16'h0);
      if (dp && d_req === 1'b0) dp = 0;
      else ip = 0;
    end
    d_req = 1'b0; i_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_busy;
    test_arbitration;
    test_err;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: memory read latency in cycles from mem_rd assertion to valid mem_rdata; legal range 1..7.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port d_req, input, 1: data-cache access request; held with its fields until d_ack.
REQ-005 SHALL have port d_wr, input, 1: data-cache request is a write (1) or a read (0).
REQ-006 SHALL have port d_addr, input, 16: data-cache word address.
REQ-007 SHALL have port d_wdata, input, 16: data-cache write data.
REQ-008 SHALL have port i_req, input, 1: instruction-cache read request; held with i_addr until i_ack.
REQ-009 SHALL have port i_addr, input, 16: instruction-cache address.
REQ-010 SHALL have port d_ack, output, 1: one-cycle completion pulse for the data-cache request.
REQ-011 SHALL have port i_ack, output, 1: one-cycle completion pulse for the instruction-cache request.
REQ-012 SHALL have port rdata, output, 16: registered read data, valid with the ack of a read.
REQ-013 SHALL have port err, output, 1: error flag, valid only with an ack.
REQ-014 SHALL have port mem_addr, output, 16: address to the four-banked memory.
REQ-015 SHALL have port mem_wdata, output, 16: write data to memory.
REQ-016 SHALL have port mem_wr, output, 1: one-cycle memory write strobe.
REQ-017 SHALL have port mem_rd, output, 1: one-cycle memory read strobe.
REQ-018 SHALL have port mem_rdata, input, 16: memory read data.
REQ-019 SHALL have port mem_busy, input, 4: per-bank busy; bank = addr[2:1].
REQ-020 SHALL have port mem_stall, input, 1: memory cannot accept any access this cycle.
REQ-021 SHALL have port mem_err, input, 1: memory error indication.

Function
REQ-022 SHALL implement states IDLE, ISSUE, RD_WAIT and DONE, with one access outstanding at a time.
REQ-023 IDLE: if any request is present, SHALL choose a winner, register grant/address/wdata/wr, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-024 ISSUE: when mem_busy[addr[2:1]]==0 and mem_stall==0, SHALL assert mem_rd or mem_wr for exactly that cycle and go to RD_WAIT (read) or DONE (write); otherwise SHALL hold with strobes low.
REQ-025 RD_WAIT: SHALL count RD_LAT cycles including the issue cycle, capture mem_rdata into rdata in the last counted cycle, then go to DONE.
REQ-026 DONE: SHALL pulse the ack of the granted requester only, then go to IDLE.
REQ-027 Latency with a free bank, counted from the IDLE cycle with req high (cycle 0): strobe at cycle 1, write ack at cycle 2, read ack at cycle RD_LAT+2 (cycle 4 at the default).
REQ-028 mem_addr and mem_wdata SHALL drive the registered request fields throughout ISSUE..DONE and SHALL be 0 in IDLE.
REQ-029 i_req SHALL always be treated as a read; a write request SHALL complete without updating rdata.
REQ-030 mem_err seen at any point in ISSUE..DONE SHALL set a sticky flag; err SHALL equal that flag during DONE and be 0 otherwise; the flag SHALL clear on entry to IDLE.
REQ-031 Request input changes after grant SHALL be ignored until DONE; dropping req mid-access SHALL still produce the ack.
REQ-032 A requester SHALL deassert req in the cycle after its ack unless it has a new access; a req still high in IDLE is a new access.

Reset
REQ-033 rst SHALL asynchronously force IDLE, clear counter, grant, error flag and rdata to 0, and drive all outputs to 0.
REQ-034 Reset mid-access SHALL abandon the access with no ack and no strobe in the following cycle.

Configuration
REQ-035 With ARB_RR_EN defined: round-robin arbitration; on simultaneous requests the winner SHALL be the requester not granted last, and after reset the data cache SHALL be treated as last granted.
REQ-036 Without ARB_RR_EN: fixed priority; d_req SHALL always win over i_req.

Verification
REQ-037 d_req=1, d_wr=1, d_addr=0x0010, d_wdata=0xBEEF with all banks free -> mem_wr at cycle 1 with mem_addr=0x0010, d_ack at cycle 2, err=0.
REQ-038 i_req=1, i_addr=0x0004, mem_rdata=0x1234 two cycles after mem_rd -> i_ack at cycle 4 with rdata=0x1234.
REQ-039 i_req=1, i_addr=0x0002, mem_busy=4'b0010 for 3 cycles -> mem_rd held off until mem_busy[1]=0, then i_ack RD_LAT+1 cycles after mem_rd.
REQ-040 d_req and i_req rising together, each held until acked -> without ARB_RR_EN, data is served first; with ARB_RR_EN, data is served first and instruction next; repeating with both requests held continuously alternates the grants.
REQ-041 mem_err=1 one cycle after mem_rd -> ack with err=1; the next access returns err=0.
REQ-042 rst asserted in RD_WAIT -> outputs 0 immediately, no ack; after release, a pending i_req is served normally.
